// File: rtl/event_counter.sv
// Up/down event counter with optional prescaler, wrap or saturate at 0..MAX_COUNT,
// load, clear, a one-cycle terminal-count pulse and a sticky overflow flag.
module event_counter #(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
  parameter bit               SATURATE  = 1'b0,
  parameter int unsigned      PRESCALE  = 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             evt_in,
  input  logic             dir_in,
  input  logic             clear_in,
  input  logic             load_in,
  input  logic [WIDTH-1:0] load_val_in,
  output logic [WIDTH-1:0] count_out,
  output logic             tc_out,
  output logic             at_bound_out,
  output logic             ovf_out
);

  localparam int unsigned   PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH:0] MAX_EXT = {1'b0, MAX_COUNT};

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    ps_q, ps_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   inc_ext, dec_ext;
  logic             step;

  // One extra bit so the upper bound is found against MAX_COUNT, not 2^WIDTH,
  // and the lower bound shows up as a borrow.
  assign inc_ext = {1'b0, count_q} + (WIDTH+1)'(1);
  assign dec_ext = {1'b0, count_q} - (WIDTH+1)'(1);
  assign step    = evt_in && (ps_q == PS_LAST);

  always_comb begin
    count_d = count_q;
    ps_d    = ps_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (clear_in) begin
      count_d = '0;
      ps_d    = '0;
      ovf_d   = 1'b0;
    end else if (load_in) begin
      count_d = (load_val_in > MAX_COUNT) ? MAX_COUNT : load_val_in;
      ps_d    = '0;
    end else if (evt_in) begin
      if (!step) begin
        ps_d = ps_q + PW'(1);
      end else begin
        ps_d = '0;
        if (!dir_in) begin
          if (inc_ext > MAX_EXT) begin
            tc_d    = 1'b1;
            ovf_d   = 1'b1;
            count_d = SATURATE ? count_q : '0;
          end else begin
            count_d = inc_ext[WIDTH-1:0];
          end
        end else begin
          if (dec_ext[WIDTH]) begin
            tc_d    = 1'b1;
            ovf_d   = 1'b1;
            count_d = SATURATE ? count_q : MAX_COUNT;
          end else begin
            count_d = dec_ext[WIDTH-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_q <= '0;
      ps_q    <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ps_q    <= ps_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_out    = count_q;
  assign tc_out       = tc_q;
  assign ovf_out      = ovf_q;
  assign at_bound_out = dir_in ? (count_q == '0) : (count_q == MAX_COUNT);

endmodule
